// File: rtl/data_mem_unit.sv
// Byte-addressed data memory serving CU load/store requests: wait states, b/bu/h/hu/w access.
// Encodings: req_type me_rd=0 me_wr=1 me_x=2; req_mask mt_b=0 mt_bu=1 mt_h=2 mt_hu=3 mt_w=4 mt_x=5.
module data_mem_unit #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MEM_BYTES   = 65536,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [31:0]       i_req_addr,
   input  logic [DATA_W-1:0] i_req_data,
   input  logic [2:0]        i_req_mask,
   input  logic [1:0]        i_req_type,
   output logic              o_resp_valid,
   input  logic              i_resp_ready,
   output logic [DATA_W-1:0] o_resp_data,
   output logic              o_resp_err
);
   localparam int unsigned AW = $clog2(MEM_BYTES);

   localparam logic [1:0] MeRd = 2'd0;
   localparam logic [1:0] MeWr = 2'd1;
   localparam logic [2:0] MtB  = 3'd0;
   localparam logic [2:0] MtBu = 3'd1;
   localparam logic [2:0] MtH  = 3'd2;
   localparam logic [2:0] MtHu = 3'd3;
   localparam logic [2:0] MtW  = 3'd4;

   typedef enum logic [1:0] {StIdle, StWait, StExec, StResp} state_t;

   state_t            r_state, w_state_d;
   logic [3:0]        r_cnt;
   logic [31:0]       r_addr;
   logic [DATA_W-1:0] r_data;
   logic [2:0]        r_mask;
   logic [1:0]        r_type;
   logic [DATA_W-1:0] r_resp_data;
   logic              r_resp_err;
   logic [7:0]        r_mem [MEM_BYTES];

   logic              w_accept, w_done, w_wait_end;
   logic [2:0]        w_size;
   logic              w_mask_ok, w_type_ok, w_misalign, w_oor, w_err, w_wr_en;
   logic [32:0]       w_end;
   logic [AW-1:0]     w_idx;
   logic [7:0]        w_b0, w_b1, w_b2, w_b3;
   logic [DATA_W-1:0] w_load;

   assign w_accept   = (r_state == StIdle) && i_req_valid;
   assign w_done     = (r_state == StResp) && i_resp_ready;
   assign w_wait_end = (r_cnt == 4'(WAIT_STATES - 1));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= StIdle;
      else          r_state <= w_state_d;
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (i_req_valid) w_state_d = (WAIT_STATES > 0) ? StWait : StExec;
         StWait:  if (w_wait_end) w_state_d = StExec;
         StExec:  w_state_d = StResp;
         StResp:  if (i_resp_ready) w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   always_comb begin
      w_size    = 3'd1;
      w_mask_ok = 1'b1;
      case (r_mask)
         MtB, MtBu: w_size = 3'd1;
         MtH, MtHu: w_size = 3'd2;
         MtW:       w_size = 3'd4;
         default:   w_mask_ok = 1'b0;
      endcase
   end

   // Range check in 33 bits so an access straddling the 4 GiB wrap is still caught.
   assign w_type_ok  = (r_type == MeRd) || (r_type == MeWr);
   assign w_misalign = ((w_size == 3'd2) && r_addr[0]) ||
                       ((w_size == 3'd4) && (r_addr[1:0] != 2'b00));
   assign w_end      = {1'b0, r_addr} + {30'd0, w_size} - 33'd1;
   assign w_oor      = (w_end >= 33'(MEM_BYTES));
   assign w_err      = !w_type_ok || !w_mask_ok || w_misalign || w_oor;
   assign w_wr_en    = i_rst_n && (r_state == StExec) && !w_err && (r_type == MeWr);

   assign w_idx = r_addr[AW-1:0];
   assign w_b0  = r_mem[w_idx];
   assign w_b1  = r_mem[w_idx + AW'(1)];
   assign w_b2  = r_mem[w_idx + AW'(2)];
   assign w_b3  = r_mem[w_idx + AW'(3)];

   always_comb begin
      w_load = '0;
      case (r_mask)
         MtB:     w_load = {{24{w_b0[7]}}, w_b0};
         MtBu:    w_load = {24'd0, w_b0};
         MtH:     w_load = {{16{w_b1[7]}}, w_b1, w_b0};
         MtHu:    w_load = {16'd0, w_b1, w_b0};
         MtW:     w_load = {w_b3, w_b2, w_b1, w_b0};
         default: w_load = '0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt       <= '0;
         r_addr      <= '0;
         r_data      <= '0;
         r_mask      <= '0;
         r_type      <= '0;
         r_resp_data <= '0;
         r_resp_err  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr <= i_req_addr;
            r_data <= i_req_data;
            r_mask <= i_req_mask;
            r_type <= i_req_type;
            r_cnt  <= '0;
         end
         if (r_state == StWait) r_cnt <= r_cnt + 4'd1;
         if (r_state == StExec) begin
            r_resp_err  <= w_err;
            r_resp_data <= (w_err || (r_type == MeWr)) ? '0 : w_load;
         end
         if (w_done) begin
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
         end
      end
   end

   // Storage has no reset; contents survive rst_n.
   always_ff @(posedge i_clk) begin
      if (w_wr_en) begin
         r_mem[w_idx] <= r_data[7:0];
         if (w_size != 3'd1) r_mem[w_idx + AW'(1)] <= r_data[15:8];
         if (w_size == 3'd4) begin
            r_mem[w_idx + AW'(2)] <= r_data[23:16];
            r_mem[w_idx + AW'(3)] <= r_data[31:24];
         end
      end
   end

   assign o_req_ready  = (r_state == StIdle);
   assign o_resp_valid = (r_state == StResp);
   assign o_resp_data  = r_resp_data;
   assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: directed scenarios plus random traffic against a
// byte-level reference model.
module tb_data_mem_unit;
   localparam int unsigned MEM_BYTES = 65536;
   localparam int unsigned WS        = 1;

   localparam logic [1:0] ME_RD = 2'd0;
   localparam logic [1:0] ME_WR = 2'd1;
   localparam logic [1:0] ME_X  = 2'd2;
   localparam logic [2:0] MT_B  = 3'd0;
   localparam logic [2:0] MT_BU = 3'd1;
   localparam logic [2:0] MT_H  = 3'd2;
   localparam logic [2:0] MT_HU = 3'd3;
   localparam logic [2:0] MT_W  = 3'd4;

   logic        i_clk = 1'b0;
   logic        i_rst_n, i_req_valid, i_resp_ready;
   logic [31:0] i_req_addr, i_req_data;
   logic [2:0]  i_req_mask;
   logic [1:0]  i_req_type;
   logic        o_req_ready, o_resp_valid, o_resp_err;
   logic [31:0] o_resp_data;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   logic [7:0] ref_mem [int];

   data_mem_unit #(
      .DATA_W      (32),
      .MEM_BYTES   (MEM_BYTES),
      .WAIT_STATES (WS)
   ) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_req_valid  (i_req_valid),
      .o_req_ready  (o_req_ready),
      .i_req_addr   (i_req_addr),
      .i_req_data   (i_req_data),
      .i_req_mask   (i_req_mask),
      .i_req_type   (i_req_type),
      .o_resp_valid (o_resp_valid),
      .i_resp_ready (i_resp_ready),
      .o_resp_data  (o_resp_data),
      .o_resp_err   (o_resp_err)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (got === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int size_of(input logic [2:0] m);
      case (m)
         MT_B, MT_BU: return 1;
         MT_H, MT_HU: return 2;
         MT_W:        return 4;
         default:     return 0;
      endcase
   endfunction

   // Reference: a dictionary of bytes, legality from the access rules, extension by arithmetic.
   function automatic void model(input logic [1:0] t, input logic [2:0] m, input logic [31:0] a,
                                 input logic [31:0] d, output logic [31:0] exp_d,
                                 output logic exp_e);
      int sz;
      longint unsigned v, last;
      sz    = size_of(m);
      last  = longint'(a) + longint'(sz) - 1;
      exp_d = '0;
      exp_e = !(t == ME_RD || t == ME_WR) || (sz == 0);
      if (!exp_e) exp_e = ((a % sz) != 0) || (last >= MEM_BYTES);
      if (exp_e) return;
      if (t == ME_WR) begin
         for (int i = 0; i < sz; i++) ref_mem[int'(a) + i] = 8'((d >> (8 * i)) & 32'hFF);
      end else begin
         v = 0;
         for (int i = 0; i < sz; i++) v = v + (longint'(ref_mem[int'(a) + i]) << (8 * i));
         if ((m == MT_B || m == MT_H) && v >= (64'd1 << (8 * sz - 1)))
            v = v + (64'd1 << 32) - (64'd1 << (8 * sz));
         exp_d = 32'(v);
      end
   endfunction

   task automatic scramble();
      i_req_addr = $urandom;
      i_req_data = $urandom;
      i_req_mask = 3'($urandom);
      i_req_type = 2'($urandom);
   endtask

   // One full transaction, entered and left on a falling edge.
   task automatic xact(input logic [1:0] t, input logic [2:0] m, input logic [31:0] a,
                       input logic [31:0] d, input int hold, output logic [31:0] got);
      logic [31:0] exp_d;
      logic        exp_e;
      int          lat, guard;
      model(t, m, a, d, exp_d, exp_e);
      guard = 0;
      while (!o_req_ready && guard < 20) begin
         @(negedge i_clk);
         guard++;
      end
      check("req_ready", 32'(o_req_ready), 32'd1);
      i_req_valid = 1'b1;
      i_req_type  = t;
      i_req_mask  = m;
      i_req_addr  = a;
      i_req_data  = d;
      @(negedge i_clk);
      i_req_valid = 1'b0;
      scramble();
      lat = 1;
      while (!o_resp_valid && lat < 40) begin
         @(negedge i_clk);
         lat++;
      end
      check("latency", 32'(lat), 32'(WS + 2));
      if (hold > 0) begin
         i_req_valid = 1'b1;
         repeat (hold) begin
            @(negedge i_clk);
            check("bp_valid", 32'(o_resp_valid), 32'd1);
            check("bp_ready", 32'(o_req_ready), 32'd0);
            check("bp_data", o_resp_data, exp_d);
         end
      end
      check("resp_data", o_resp_data, exp_d);
      check("resp_err", 32'(o_resp_err), 32'(exp_e));
      got = o_resp_data;
      i_resp_ready = 1'b1;
      @(negedge i_clk);
      i_resp_ready = 1'b0;
      check("post_valid", 32'(o_resp_valid), 32'd0);
      check("post_ready", 32'(o_req_ready), 32'd1);
      i_req_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] got;
      logic [1:0]  t;
      logic [2:0]  m;
      logic [31:0] a;
      int          r;

      i_rst_n      = 1'b0;
      i_req_valid  = 1'b0;
      i_resp_ready = 1'b0;
      scramble();
      repeat (2) @(negedge i_clk);
      check("rst_req_ready", 32'(o_req_ready), 32'd1);
      check("rst_resp_valid", 32'(o_resp_valid), 32'd0);
      check("rst_resp_data", o_resp_data, 32'd0);
      check("rst_resp_err", 32'(o_resp_err), 32'd0);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      for (int w = 0; w < 16; w++) xact(ME_WR, MT_W, 32'h100 + 32'(4 * w), $urandom, 0, got);
      xact(ME_WR, MT_W, 32'hFFFC, 32'hA1B2C3D4, 0, got);
      xact(ME_WR, MT_W, 32'h200, 32'h0BADF00D, 0, got);

      xact(ME_WR, MT_W, 32'h100, 32'hDEADBEEF, 0, got);
      check("sw_data_zero", got, 32'd0);
      xact(ME_RD, MT_W, 32'h100, $urandom, 0, got);
      check("lw_100", got, 32'hDEADBEEF);

      xact(ME_RD, MT_B, 32'h103, 0, 0, got);
      check("lb_103", got, 32'hFFFFFFDE);
      xact(ME_RD, MT_BU, 32'h103, 0, 0, got);
      check("lbu_103", got, 32'h000000DE);
      xact(ME_RD, MT_H, 32'h100, 0, 0, got);
      check("lh_100", got, 32'hFFFFBEEF);
      xact(ME_RD, MT_HU, 32'h102, 0, 0, got);
      check("lhu_102", got, 32'h0000DEAD);
      xact(ME_WR, MT_B, 32'h101, 32'hFFFFFF12, 0, got);
      xact(ME_RD, MT_W, 32'h100, 0, 0, got);
      check("lw_after_sb", got, 32'hDEAD12EF);

      xact(ME_RD, MT_W, 32'h102, 0, 0, got);
      xact(ME_WR, MT_H, 32'h101, 32'h7777, 0, got);
      xact(ME_RD, MT_W, MEM_BYTES, 0, 0, got);
      xact(ME_X, MT_W, 32'h100, 32'h1111, 0, got);
      xact(ME_WR, 3'd5, 32'h100, 32'h2222, 0, got);
      xact(ME_RD, MT_W, 32'h100, 0, 0, got);
      check("lw_after_errs", got, 32'hDEAD12EF);

      xact(ME_RD, MT_W, 32'h100, 0, 5, got);
      check("lw_backpressure", got, 32'hDEAD12EF);

      xact(ME_RD, MT_W, 32'hFFFC, 0, 0, got);
      check("lw_top", got, 32'hA1B2C3D4);
      xact(ME_RD, MT_H, 32'hFFFE, 0, 0, got);
      check("lh_top", got, 32'hFFFFA1B2);
      xact(ME_RD, MT_BU, 32'hFFFF, 0, 0, got);
      check("lbu_top", got, 32'h000000A1);
      xact(ME_RD, MT_H, 32'hFFFF, 0, 0, got);
      xact(ME_RD, MT_B, 32'h10000, 0, 0, got);
      xact(ME_WR, MT_W, 32'hFFFD, 32'h3333, 0, got);

      i_req_valid = 1'b1;
      i_req_type  = ME_WR;
      i_req_mask  = MT_W;
      i_req_addr  = 32'h200;
      i_req_data  = 32'h55;
      @(negedge i_clk);
      i_req_valid = 1'b0;
      check("mid_not_ready", 32'(o_req_ready), 32'd0);
      i_rst_n = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      check("mid_rst_ready", 32'(o_req_ready), 32'd1);
      repeat (4) @(negedge i_clk);
      check("mid_rst_no_resp", 32'(o_resp_valid), 32'd0);
      xact(ME_RD, MT_W, 32'h200, 0, 0, got);
      check("lw_200_kept", got, 32'h0BADF00D);

      for (int k = 0; k < 150; k++) begin
         r = int'($urandom_range(0, 9));
         t = (r < 4) ? ME_RD : (r < 8) ? ME_WR : (r == 8) ? ME_X : 2'd3;
         m = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) a = 32'hFFFC + $urandom_range(0, 7);
         else                           a = 32'h100 + $urandom_range(0, 63);
         xact(t, m, a, $urandom, int'($urandom_range(0, 3)), got);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
